// File: rtl/mreq_bus_master_pkg.sv
// mreq_bus_master_pkg
// Shared definitions for the host-command bus master:
//   - MREQ_NBIT and the packed memory-request layout {tag, wr, aincr, wfmt, wcnt, addr}
//   - wfmt encodings (bytes per word minus one) and the largest legal value
//   - FSM state type for the top level
//   - unpack_mreq / pack_mreq helpers
package mreq_bus_master_pkg;

  localparam int unsigned MREQ_NBIT = 45;

  localparam logic [2:0] MREQ_WFMT_B1       = 3'd0;
  localparam logic [2:0] MREQ_WFMT_B2       = 3'd1;
  localparam logic [2:0] MREQ_WFMT_B3       = 3'd2;
  localparam logic [2:0] MREQ_WFMT_B4       = 3'd3;
  localparam logic [2:0] MREQ_WFMT_MAXVALID = MREQ_WFMT_B4;

  typedef struct packed {
    logic [7:0]  tag;
    logic        wr;
    logic        aincr;
    logic [2:0]  wfmt;
    logic [7:0]  wcnt;
    logic [23:0] addr;
  } mreq_t;

  typedef enum logic [2:0] {
    StIdle,
    StWgath,
    StWbus,
    StRbus,
    StRser,
    StDone
  } state_e;

  function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] raw);
    return mreq_t'(raw);
  endfunction

  function automatic logic [MREQ_NBIT-1:0] pack_mreq(input mreq_t req);
    return MREQ_NBIT'(req);
  endfunction

endpackage

// File: rtl/mreq_bus_master_if.sv
// mreq_bus_master_if
// Groups the request handshake, the write/read payload byte streams and the word bus of
// mreq_bus_master. Signal names keep the block's i_/o_ direction as seen from the master.
//   master : the bus master block itself
//   slave  : everything around it (cmd_rx, payload source/sink, bus fabric)
interface mreq_bus_master_if;

  // Request handshake
  logic                                       i_mreq_valid;
  logic                                       o_mreq_ready;
  logic [mreq_bus_master_pkg::MREQ_NBIT-1:0]  i_mreq;

  // Write payload bytes in
  logic                                       i_wd_valid;
  logic [7:0]                                 i_wd_data;
  logic                                       o_wd_ready;

  // Read payload bytes out
  logic                                       o_rd_valid;
  logic [7:0]                                 o_rd_data;
  logic                                       i_rd_ready;

  // Word bus
  logic                                       o_bus_cyc;
  logic                                       o_bus_we;
  logic [23:0]                                o_bus_addr;
  logic [31:0]                                o_bus_wdata;
  logic                                       i_bus_ack;
  logic [31:0]                                i_bus_rdata;

  modport master (
    input  i_mreq_valid, i_mreq, i_wd_valid, i_wd_data, i_rd_ready, i_bus_ack, i_bus_rdata,
    output o_mreq_ready, o_wd_ready, o_rd_valid, o_rd_data,
           o_bus_cyc, o_bus_we, o_bus_addr, o_bus_wdata
  );

  modport slave (
    output i_mreq_valid, i_mreq, i_wd_valid, i_wd_data, i_rd_ready, i_bus_ack, i_bus_rdata,
    input  o_mreq_ready, o_wd_ready, o_rd_valid, o_rd_data,
           o_bus_cyc, o_bus_we, o_bus_addr, o_bus_wdata
  );

endinterface

// File: rtl/mreq_word_shifter.sv
// mreq_word_shifter
// 32-bit byte shift register shared by write packing and read unpacking.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_load, i_load_data parallel load (clears the byte counter)
//   i_shift_in, i_byte  shift one byte in (pack, little-endian)
//   i_shift_out         shift one byte out (unpack, low byte first)
//   i_last_idx          index of the last byte of a word (wfmt[1:0])
//   o_data, o_byte      whole word / current low byte
//   o_last              byte counter is at the last byte of the word
module mreq_word_shifter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic        i_shift_in,
  input  logic [7:0]  i_byte,
  input  logic        i_shift_out,
  input  logic [1:0]  i_last_idx,
  output logic [31:0] o_data,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (i_load) begin
      data_d = i_load_data;
      cnt_d  = 2'd0;
    end else if (i_shift_in) begin
      // Shift right and insert at the top of the word's byte window, so after the last
      // byte the first byte sits in bits 7:0 and the bytes above the window stay zero.
      data_d = data_q >> 8;
      data_d[{i_last_idx, 3'b000} +: 8] = i_byte;
      cnt_d  = cnt_q + 2'd1;
    end else if (i_shift_out) begin
      data_d = data_q >> 8;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data = data_q;
  assign o_byte = data_q[7:0];
  assign o_last = (cnt_q == i_last_idx);

endmodule

// File: rtl/mreq_bus_master.sv
// mreq_bus_master
// Executes memory requests as wcnt+1 word cycles on the register/memory bus, packing
// write payload bytes into words and unpacking read words into payload bytes.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             request handshake, payload byte streams and word bus (master modport)
//   o_busy          FSM not idle
//   o_done          one-cycle pulse when a request completes or is rejected
//   o_done_tag      tag of the last completed/rejected request
//   o_err_fmt       one-cycle pulse with o_done when wfmt was reserved
module mreq_bus_master
  import mreq_bus_master_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  mreq_bus_master_if.master        bus,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [7:0]               o_done_tag,
  output logic                     o_err_fmt
);

  state_e      state_q, state_d;
  logic [7:0]  tag_q, tag_d;
  logic        aincr_q, aincr_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [8:0]  count_q, count_d;   // words still to move on the bus
  logic [23:0] addr_q, addr_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  done_tag_q, done_tag_d;
  logic        err_fmt_q, err_fmt_d;

  logic        sh_load;
  logic [31:0] sh_load_data;
  logic        sh_shift_in;
  logic        sh_shift_out;
  logic [31:0] sh_data;
  logic [7:0]  sh_byte;
  logic        sh_last;

  mreq_t req;
  assign req = unpack_mreq(bus.i_mreq);

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    aincr_d      = aincr_q;
    fmt_d        = fmt_q;
    count_d      = count_q;
    addr_d       = addr_q;
    done_tag_d   = done_tag_q;
    err_fmt_d    = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_shift_in  = 1'b0;
    sh_shift_out = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_mreq_valid) begin
          tag_d   = req.tag;
          aincr_d = req.aincr;
          fmt_d   = req.wfmt[1:0];
          count_d = {1'b0, req.wcnt} + 9'd1;
          addr_d  = req.addr;
          sh_load = 1'b1;
          if (req.wfmt > MREQ_WFMT_MAXVALID) begin
            state_d   = StDone;
            err_fmt_d = 1'b1;
          end else if (req.wr) begin
            state_d = StWgath;
          end else begin
            state_d = StRbus;
          end
        end
      end
      StWgath: begin
        if (bus.i_wd_valid) begin
          sh_shift_in = 1'b1;
          if (sh_last) state_d = StWbus;
        end
      end
      StWbus: begin
        if (bus.i_bus_ack) begin
          count_d = count_q - 9'd1;
          if (aincr_q) addr_d = addr_q + 24'd1;
          if (count_q != 9'd1) begin
            state_d = StWgath;
            sh_load = 1'b1;   // clear so unused upper bytes of the next word are zero
          end else begin
            state_d = StDone;
          end
        end
      end
      StRbus: begin
        if (bus.i_bus_ack) begin
          count_d      = count_q - 9'd1;
          if (aincr_q) addr_d = addr_q + 24'd1;
          sh_load      = 1'b1;
          sh_load_data = bus.i_bus_rdata;
          state_d      = StRser;
        end
      end
      StRser: begin
        if (bus.i_rd_ready) begin
          sh_shift_out = 1'b1;
          if (sh_last) state_d = (count_q != 9'd0) ? StRbus : StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Bus and status outputs are registered, so they follow the next state.
    cyc_d  = (state_d == StWbus) || (state_d == StRbus);
    we_d   = (state_d == StWbus);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    if (done_d) done_tag_d = tag_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      aincr_q    <= 1'b0;
      fmt_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_tag_q <= '0;
      err_fmt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      aincr_q    <= aincr_d;
      fmt_q      <= fmt_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_tag_q <= done_tag_d;
      err_fmt_q  <= err_fmt_d;
    end
  end

  mreq_word_shifter u_shifter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (sh_load),
    .i_load_data (sh_load_data),
    .i_shift_in  (sh_shift_in),
    .i_byte      (bus.i_wd_data),
    .i_shift_out (sh_shift_out),
    .i_last_idx  (fmt_q),
    .o_data      (sh_data),
    .o_byte      (sh_byte),
    .o_last      (sh_last)
  );

  assign bus.o_mreq_ready = (state_q == StIdle);
  assign bus.o_wd_ready   = (state_q == StWgath);
  assign bus.o_rd_valid   = (state_q == StRser);
  assign bus.o_rd_data    = sh_byte;
  assign bus.o_bus_cyc    = cyc_q;
  assign bus.o_bus_we     = we_q;
  assign bus.o_bus_addr   = addr_q;
  // The shifter is frozen while a write cycle is open, so wdata holds steady until ack.
  assign bus.o_bus_wdata  = sh_data;

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_done_tag = done_tag_q;
  assign o_err_fmt  = err_fmt_q;

endmodule

// File: tb/tb_mreq_bus_master.sv
module tb_mreq_bus_master;
  import mreq_bus_master_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_done_tag;
  logic       o_err_fmt;

  mreq_bus_master_if bus();

  mreq_bus_master dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_done_tag (o_done_tag),
    .o_err_fmt  (o_err_fmt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_n  = 0;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tag;
  logic        exp_err;
  logic [23:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  logic [7:0]  obs_rd[$];
  logic [7:0]  src_bytes[$];
  logic [7:0]  wd_q[$];
  int          done_cnt = 0;
  logic        err_seen = 1'b0;
  int unsigned done_cycle = 0;
  int unsigned acc_cycle = 0;
  logic        mon_en = 1'b0;

  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] rdata_cfg = '0;
  logic        rd_toggle = 1'b0;
  logic        wd_fire = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(posedge clk) wd_fire <= bus.i_wd_valid && bus.o_wd_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave: ack after ack_delay idle cycles of cyc, drop ack once it has been sampled.
  initial begin
    bus.i_bus_ack   = 1'b0;
    bus.i_bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.i_bus_ack || !bus.o_bus_cyc) begin
        bus.i_bus_ack   = 1'b0;
        bus.i_bus_rdata = '0;
        wait_cnt        = 0;
      end else if (wait_cnt >= ack_delay) begin
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = rdata_cfg;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Write payload source.
  initial begin
    bus.i_wd_valid = 1'b0;
    bus.i_wd_data  = '0;
    forever begin
      @(negedge clk);
      if (wd_fire && wd_q.size() > 0) void'(wd_q.pop_front());
      bus.i_wd_valid = (wd_q.size() > 0);
      bus.i_wd_data  = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
    end
  end

  // Read payload sink.
  initial begin
    bus.i_rd_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.i_rd_ready = rd_toggle ? ~bus.i_rd_ready : 1'b1;
    end
  end

  // Compare process: checks outputs against the expected transaction queues every cycle.
  initial begin
    logic        prev_cyc, prev_ack, prev_we;
    logic [23:0] prev_addr;
    logic [31:0] prev_wdata;
    bus_exp_t    e;
    logic [7:0]  b;
    prev_cyc = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n) begin
        chk("ready_is_not_busy", 32'(bus.o_mreq_ready), 32'(!o_busy));
        if (bus.o_bus_cyc) begin
          if (prev_cyc && !prev_ack) begin
            chk("cyc_addr_stable", 32'(bus.o_bus_addr), 32'(prev_addr));
            chk("cyc_we_stable", 32'(bus.o_bus_we), 32'(prev_we));
            chk("cyc_wdata_stable", bus.o_bus_wdata, prev_wdata);
          end
          if (bus.i_bus_ack) begin
            chk("bus_cycle_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
              e = exp_bus.pop_front();
              chk("bus_addr", 32'(bus.o_bus_addr), 32'(e.addr));
              chk("bus_we", 32'(bus.o_bus_we), 32'(e.we));
              if (e.we) chk("bus_wdata", bus.o_bus_wdata, e.wdata);
            end
            obs_addr.push_back(bus.o_bus_addr);
            obs_wdata.push_back(bus.o_bus_wdata);
          end
        end
        if (bus.o_rd_valid && bus.i_rd_ready) begin
          chk("rd_byte_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) begin
            b = exp_rd.pop_front();
            chk("rd_data", 32'(bus.o_rd_data), 32'(b));
          end
          obs_rd.push_back(bus.o_rd_data);
        end
        if ((bus.o_rd_valid && !bus.i_rd_ready) || (bus.o_wd_ready && !bus.i_wd_valid))
          chk("cyc_low_in_stall", 32'(bus.o_bus_cyc), 32'd0);
        if (o_done) begin
          chk("done_tag", 32'(o_done_tag), 32'(exp_tag));
          chk("done_err_fmt", 32'(o_err_fmt), 32'(exp_err));
          done_cnt++;
          done_cycle = cyc_n;
          if (o_err_fmt) err_seen = 1'b1;
        end else begin
          chk("err_without_done", 32'(o_err_fmt), 32'd0);
        end
        prev_cyc   = bus.o_bus_cyc;
        prev_ack   = bus.i_bus_ack;
        prev_we    = bus.o_bus_we;
        prev_addr  = bus.o_bus_addr;
        prev_wdata = bus.o_bus_wdata;
      end else begin
        prev_cyc = 1'b0;
        prev_ack = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mreq_ready"}, 32'(bus.o_mreq_ready), 32'd1);
    chk({tag, "_wd_ready"}, 32'(bus.o_wd_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.o_rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'd0);
    chk({tag, "_cyc"}, 32'(bus.o_bus_cyc), 32'd0);
    chk({tag, "_we"}, 32'(bus.o_bus_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.o_bus_addr), 32'd0);
    chk({tag, "_wdata"}, bus.o_bus_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_done_tag"}, 32'(o_done_tag), 32'd0);
    chk({tag, "_err_fmt"}, 32'(o_err_fmt), 32'd0);
  endtask

  // Builds the expected bus cycles / read bytes from the request fields, then issues it.
  task automatic send_req(input logic [7:0] tag, input logic wr, input logic aincr,
                          input logic [2:0] wfmt, input logic [7:0] wcnt,
                          input logic [23:0] addr);
    mreq_t       m;
    bus_exp_t    be;
    int          n, words, bi;
    logic [31:0] w;
    exp_bus.delete(); exp_rd.delete();
    obs_addr.delete(); obs_wdata.delete(); obs_rd.delete();
    done_cnt = 0;
    err_seen = 1'b0;
    exp_tag  = tag;
    exp_err  = (wfmt > 3'd3);
    if (!exp_err) begin
      n = int'(wfmt) + 1;
      words = int'(wcnt) + 1;
      bi = 0;
      for (int k = 0; k < words; k++) begin
        be.addr = aincr ? addr + 24'(k) : addr;
        be.we   = wr;
        w = '0;
        if (wr) begin
          for (int i = 0; i < n; i++) begin
            w = w | (32'(src_bytes[bi]) << (8 * i));
            bi++;
          end
        end else begin
          for (int i = 0; i < n; i++) exp_rd.push_back(8'(rdata_cfg >> (8 * i)));
        end
        be.wdata = w;
        exp_bus.push_back(be);
      end
    end
    if (wr && !exp_err) wd_q = src_bytes;
    m.tag = tag; m.wr = wr; m.aincr = aincr; m.wfmt = wfmt; m.wcnt = wcnt; m.addr = addr;
    @(negedge clk);
    chk("mreq_ready_before_send", 32'(bus.o_mreq_ready), 32'd1);
    bus.i_mreq       = pack_mreq(m);
    bus.i_mreq_valid = 1'b1;
    acc_cycle        = cyc_n;
    @(negedge clk);
    bus.i_mreq_valid = 1'b0;
  endtask

  task automatic finish_req(input string name, input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_within_budget"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_bus_queue_drained"}, 32'(exp_bus.size()), 32'd0);
    chk({name, "_rd_queue_drained"}, 32'(exp_rd.size()), 32'd0);
    chk({name, "_wd_consumed"}, 32'(wd_q.size()), 32'd0);
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int t;
    rst_n            = 1'b0;
    bus.i_mreq_valid = 1'b0;
    bus.i_mreq       = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1-word write, 1 byte: done three cycles after accept
    src_bytes = '{8'h5A};
    send_req(8'h31, 1'b1, 1'b0, 3'd0, 8'h00, 24'h000100);
    finish_req("w1", 50);
    chk("w1_latency", done_cycle - acc_cycle, 32'd3);
    chk("w1_wdata", obs_wdata[0], 32'h0000005A);

    // 1-word read, 4 bytes: done six cycles after accept
    rdata_cfg = 32'h04030201;
    send_req(8'h32, 1'b0, 1'b0, 3'd3, 8'h00, 24'h000200);
    finish_req("r1", 50);
    chk("r1_latency", done_cycle - acc_cycle, 32'd6);
    chk("r1_byte0", 32'(obs_rd[0]), 32'h01);
    chk("r1_byte3", 32'(obs_rd[3]), 32'h04);

    // Two 4-byte words with auto-increment
    src_bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    send_req(8'hEA, 1'b1, 1'b1, 3'd3, 8'h01, 24'h123456);
    finish_req("w2", 100);
    chk("w2_addr0", 32'(obs_addr[0]), 32'h123456);
    chk("w2_wdata0", obs_wdata[0], 32'h14131211);
    chk("w2_addr1", 32'(obs_addr[1]), 32'h123457);
    chk("w2_wdata1", obs_wdata[1], 32'h18171615);
    chk("w2_done_tag", 32'(o_done_tag), 32'hEA);

    // Three 2-byte reads, fixed address
    rdata_cfg = 32'hDEADBEEF;
    send_req(8'h41, 1'b0, 1'b0, 3'd1, 8'h02, 24'hAABBCC);
    finish_req("r3", 100);
    chk("r3_nbytes", 32'(obs_rd.size()), 32'd6);
    chk("r3_byte0", 32'(obs_rd[0]), 32'hEF);
    chk("r3_byte1", 32'(obs_rd[1]), 32'hBE);
    chk("r3_byte5", 32'(obs_rd[5]), 32'hBE);
    for (int i = 0; i < 3; i++) chk("r3_addr_fixed", 32'(obs_addr[i]), 32'hAABBCC);

    // 256 single-byte writes wrapping the 24-bit address
    src_bytes.delete();
    for (int i = 0; i < 256; i++) src_bytes.push_back(8'(i));
    send_req(8'h99, 1'b1, 1'b1, 3'd0, 8'hFF, 24'hFFFFFF);
    finish_req("wrap", 2000);
    chk("wrap_ncycles", 32'(obs_addr.size()), 32'd256);
    chk("wrap_addr_first", 32'(obs_addr[0]), 32'hFFFFFF);
    chk("wrap_addr_second", 32'(obs_addr[1]), 32'h000000);
    chk("wrap_addr_last", 32'(obs_addr[255]), 32'h0000FE);
    chk("wrap_wdata_last", obs_wdata[255], 32'h000000FF);

    // Reserved wfmt: rejected without bus traffic
    send_req(8'h05, 1'b1, 1'b0, 3'd5, 8'h00, 24'h000300);
    finish_req("resv", 20);
    chk("resv_err_seen", 32'(err_seen), 32'd1);
    chk("resv_tag", 32'(o_done_tag), 32'h05);
    chk("resv_no_cycle", 32'(obs_addr.size()), 32'd0);
    chk("resv_latency", done_cycle - acc_cycle, 32'd1);

    // Slow ack and a stalling read sink
    ack_delay = 3;
    rd_toggle = 1'b1;
    rdata_cfg = 32'h00C0FFEE;
    send_req(8'h52, 1'b0, 1'b1, 3'd2, 8'h01, 24'h000200);
    finish_req("slow", 200);
    chk("slow_nbytes", 32'(obs_rd.size()), 32'd6);
    chk("slow_byte2", 32'(obs_rd[2]), 32'hC0);
    chk("slow_byte3", 32'(obs_rd[3]), 32'hEE);
    chk("slow_addr1", 32'(obs_addr[1]), 32'h000201);
    rd_toggle = 1'b0;

    // Reset while word 2 of a write is on the bus
    ack_delay = 5;
    src_bytes = '{8'h21, 8'h22, 8'h23, 8'h24};
    send_req(8'h66, 1'b1, 1'b1, 3'd0, 8'h03, 24'h000400);
    t = 0;
    while (!(obs_addr.size() == 1 && bus.o_bus_cyc) && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("rst_reached_word2", 32'(obs_addr.size() == 1 && bus.o_bus_cyc), 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wd_q.delete();
    exp_bus.delete();
    exp_rd.delete();
    ack_delay = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    src_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_req(8'h77, 1'b1, 1'b0, 3'd3, 8'h00, 24'h000010);
    finish_req("after_rst", 50);
    chk("after_rst_addr", 32'(obs_addr[0]), 32'h000010);
    chk("after_rst_wdata", obs_wdata[0], 32'hA4A3A2A1);
    chk("after_rst_tag", 32'(o_done_tag), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
